// File: rtl/actv_pipe_unit.sv
// actv_pipe_unit: two-stage valid/ready activation pipeline.
// Stage 1 applies the selected activation. Stage 2 applies round-half-up
// rescaling, width saturation and the optional clip ceiling.
// A sticky 16-bit counter tracks output beats that carry any saturated lane.
module actv_pipe_unit #(
    parameter int unsigned INPUT_WIDTH  = 22,
    parameter int unsigned NUM_INPUTS   = 4,
    parameter int unsigned OUTPUT_WIDTH = 16,
    parameter int unsigned FRAC_SHIFT   = 6,
    parameter int unsigned LEAK_SHIFT   = 3
) (
    input  logic                                      actv_clk,
    input  logic                                      actv_rst_b,
    input  logic [1:0]                                actv_mode_i,
    input  logic [OUTPUT_WIDTH-2:0]                   actv_clip_i,
    input  logic                                      actv_valid_i,
    output logic                                      actv_ready_o,
    input  logic [NUM_INPUTS-1:0][INPUT_WIDTH-1:0]    actv_in_i,
    output logic                                      actv_valid_o,
    input  logic                                      actv_ready_i,
    output logic [NUM_INPUTS-1:0][OUTPUT_WIDTH-1:0]   actv_out_o,
    output logic [NUM_INPUTS-1:0]                     actv_sat_o,
    input  logic                                      actv_sat_clr_i,
    output logic [15:0]                               actv_sat_cnt_o
);

    localparam int unsigned EW      = INPUT_WIDTH + 1;
    localparam int unsigned CW      = OUTPUT_WIDTH - 1;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned RND_POS = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;

    localparam logic [1:0] MODE_BYPASS = 2'b00;
    localparam logic [1:0] MODE_LEAKY  = 2'b10;
    localparam logic [1:0] MODE_CLIP   = 2'b11;

    // Rounding constant is zero when no shift is applied.
    localparam logic signed [EW-1:0] RND     = EW'((FRAC_SHIFT == 0) ? 0 : (1 << RND_POS));
    localparam logic signed [EW-1:0] OUT_MAX = EW'((2 ** (OUTPUT_WIDTH - 1)) - 1);
    localparam logic signed [EW-1:0] OUT_MIN = EW'(-(2 ** (OUTPUT_WIDTH - 1)));
    localparam logic [CNT_W-1:0]     CNT_MAX = {CNT_W{1'b1}};

    // Stage 1 registers: activated lanes plus the mode/clip that travel with the beat.
    logic                                   s1_valid_q, s1_valid_d;
    logic [NUM_INPUTS-1:0][INPUT_WIDTH-1:0] s1_y_q, s1_y_d;
    logic [1:0]                             s1_mode_q, s1_mode_d;
    logic [CW-1:0]                          s1_clip_q, s1_clip_d;

    // Stage 2 registers: final output lanes and saturation flags.
    logic                                    s2_valid_q, s2_valid_d;
    logic [NUM_INPUTS-1:0][OUTPUT_WIDTH-1:0] s2_out_q, s2_out_d;
    logic [NUM_INPUTS-1:0]                   s2_sat_q, s2_sat_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic s1_adv;
    logic s2_adv;

    // Advance conditions: a stage moves when empty or when its successor moves.
    always_comb begin
        s2_adv = ~s2_valid_q | actv_ready_i;
        s1_adv = ~s1_valid_q | s2_adv;
    end

    assign actv_ready_o = s1_adv;

    // Stage 1 next state: per-lane activation on an accepted beat.
    always_comb begin
        logic signed [INPUT_WIDTH-1:0] lane_x;
        lane_x     = '0;
        s1_valid_d = s1_valid_q;
        s1_y_d     = s1_y_q;
        s1_mode_d  = s1_mode_q;
        s1_clip_d  = s1_clip_q;
        if (s1_adv) begin
            s1_valid_d = actv_valid_i;
            if (actv_valid_i) begin
                s1_mode_d = actv_mode_i;
                s1_clip_d = actv_clip_i;
                for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                    lane_x = $signed(actv_in_i[i]);
                    case (actv_mode_i)
                        MODE_BYPASS: s1_y_d[i] = lane_x;
                        MODE_LEAKY:  s1_y_d[i] = lane_x[INPUT_WIDTH-1] ? (lane_x >>> LEAK_SHIFT) : lane_x;
                        default:     s1_y_d[i] = lane_x[INPUT_WIDTH-1] ? '0 : lane_x;
                    endcase
                end
            end
        end
    end

    // Stage 2 next state: round, shift, saturate, then clip in clipped-ReLU mode.
    always_comb begin
        logic signed [EW-1:0]           lane_ext;
        logic signed [EW-1:0]           lane_z;
        logic signed [OUTPUT_WIDTH-1:0] lane_sat;
        logic signed [OUTPUT_WIDTH-1:0] lane_clip;
        lane_ext   = '0;
        lane_z     = '0;
        lane_sat   = '0;
        lane_clip  = '0;
        s2_valid_d = s2_valid_q;
        s2_out_d   = s2_out_q;
        s2_sat_d   = s2_sat_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                lane_clip = $signed({1'b0, s1_clip_q});
                for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                    lane_ext = $signed({s1_y_q[i][INPUT_WIDTH-1], s1_y_q[i]});
                    lane_z   = (lane_ext + RND) >>> FRAC_SHIFT;
                    if (lane_z > OUT_MAX) begin
                        lane_sat    = OUTPUT_WIDTH'(OUT_MAX);
                        s2_sat_d[i] = 1'b1;
                    end else if (lane_z < OUT_MIN) begin
                        lane_sat    = OUTPUT_WIDTH'(OUT_MIN);
                        s2_sat_d[i] = 1'b1;
                    end else begin
                        lane_sat    = OUTPUT_WIDTH'(lane_z);
                        s2_sat_d[i] = 1'b0;
                    end
                    if ((s1_mode_q == MODE_CLIP) && (lane_sat > lane_clip)) begin
                        lane_sat = lane_clip;
                    end
                    s2_out_d[i] = lane_sat;
                end
            end
        end
    end

    // Saturation event counter: sticky at max, clear has priority.
    always_comb begin
        cnt_d = cnt_q;
        if (actv_sat_clr_i) begin
            cnt_d = '0;
        end else if (s2_valid_q && actv_ready_i && (|s2_sat_q) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Pipeline and counter state registers.
    always_ff @(posedge actv_clk or negedge actv_rst_b) begin
        if (!actv_rst_b) begin
            s1_valid_q <= 1'b0;
            s1_y_q     <= '0;
            s1_mode_q  <= '0;
            s1_clip_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_out_q   <= '0;
            s2_sat_q   <= '0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_y_q     <= s1_y_d;
            s1_mode_q  <= s1_mode_d;
            s1_clip_q  <= s1_clip_d;
            s2_valid_q <= s2_valid_d;
            s2_out_q   <= s2_out_d;
            s2_sat_q   <= s2_sat_d;
            cnt_q      <= cnt_d;
        end
    end

    assign actv_valid_o   = s2_valid_q;
    assign actv_out_o     = s2_out_q;
    assign actv_sat_o     = s2_sat_q;
    assign actv_sat_cnt_o = cnt_q;

endmodule

// File: tb/tb_actv_pipe_unit.sv
// Directed testbench for actv_pipe_unit with hand-computed expected values.
module tb_actv_pipe_unit;

    localparam int unsigned IW = 22;
    localparam int unsigned N  = 4;
    localparam int unsigned OW = 16;

    logic                     actv_clk;
    logic                     actv_rst_b;
    logic [1:0]               actv_mode_i;
    logic [OW-2:0]            actv_clip_i;
    logic                     actv_valid_i;
    logic                     actv_ready_o;
    logic [N-1:0][IW-1:0]     actv_in_i;
    logic                     actv_valid_o;
    logic                     actv_ready_i;
    logic [N-1:0][OW-1:0]     actv_out_o;
    logic [N-1:0]             actv_sat_o;
    logic                     actv_sat_clr_i;
    logic [15:0]              actv_sat_cnt_o;

    int vectors = 0;
    int fails   = 0;

    actv_pipe_unit #(
        .INPUT_WIDTH (IW),
        .NUM_INPUTS  (N),
        .OUTPUT_WIDTH(OW),
        .FRAC_SHIFT  (6),
        .LEAK_SHIFT  (3)
    ) dut (
        .actv_clk      (actv_clk),
        .actv_rst_b    (actv_rst_b),
        .actv_mode_i   (actv_mode_i),
        .actv_clip_i   (actv_clip_i),
        .actv_valid_i  (actv_valid_i),
        .actv_ready_o  (actv_ready_o),
        .actv_in_i     (actv_in_i),
        .actv_valid_o  (actv_valid_o),
        .actv_ready_i  (actv_ready_i),
        .actv_out_o    (actv_out_o),
        .actv_sat_o    (actv_sat_o),
        .actv_sat_clr_i(actv_sat_clr_i),
        .actv_sat_cnt_o(actv_sat_cnt_o)
    );

    initial actv_clk = 1'b0;
    always #5 actv_clk = ~actv_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_lane(input string tag, input int lane, input int exp);
        logic [OW-1:0] e;
        e = OW'(exp);
        chk($sformatf("%s lane%0d", tag, lane), {16'h0, actv_out_o[lane]}, {16'h0, e});
    endtask

    task automatic drive(input logic [1:0] mode, input logic [OW-2:0] clip,
                         input int a0, input int a1, input int a2, input int a3);
        actv_mode_i  = mode;
        actv_clip_i  = clip;
        actv_in_i[0] = IW'(a0);
        actv_in_i[1] = IW'(a1);
        actv_in_i[2] = IW'(a2);
        actv_in_i[3] = IW'(a3);
        actv_valid_i = 1'b1;
    endtask

    // One beat through an unstalled pipe: accept, check 2-cycle latency and data, then transfer.
    task automatic run_beat(input string tag, input logic [1:0] mode, input logic [OW-2:0] clip,
                            input int a0, input int a1, input int a2, input int a3,
                            input int e0, input int e1, input int e2, input int e3,
                            input logic [3:0] esat);
        drive(mode, clip, a0, a1, a2, a3);
        #1;
        chk({tag, " ready"}, 32'(actv_ready_o), 32'd1);
        @(posedge actv_clk); #1;
        actv_valid_i = 1'b0;
        chk({tag, " valid@N+1"}, 32'(actv_valid_o), 32'd0);
        @(posedge actv_clk); #1;
        chk({tag, " valid@N+2"}, 32'(actv_valid_o), 32'd1);
        chk_lane(tag, 0, e0);
        chk_lane(tag, 1, e1);
        chk_lane(tag, 2, e2);
        chk_lane(tag, 3, e3);
        chk({tag, " sat"}, 32'(actv_sat_o), 32'(esat));
        @(posedge actv_clk); #1;
    endtask

    initial begin
        actv_rst_b     = 1'b0;
        actv_mode_i    = 2'b00;
        actv_clip_i    = '0;
        actv_valid_i   = 1'b0;
        actv_ready_i   = 1'b0;
        actv_sat_clr_i = 1'b0;
        actv_in_i      = '0;

        // Reset state
        #12;
        chk("rst valid_o", 32'(actv_valid_o), 32'd0);
        chk("rst out", 32'(actv_out_o), 32'd0);
        chk("rst out hi", 32'(actv_out_o >> 32), 32'd0);
        chk("rst sat", 32'(actv_sat_o), 32'd0);
        chk("rst cnt", 32'(actv_sat_cnt_o), 32'd0);
        @(negedge actv_clk);
        actv_rst_b = 1'b1;
        @(posedge actv_clk); #1;
        chk("post-rst ready_o", 32'(actv_ready_o), 32'd1);
        chk("post-rst valid_o", 32'(actv_valid_o), 32'd0);
        actv_ready_i = 1'b1;

        // Activation modes
        run_beat("relu", 2'b01, '0, -100, 640, 0, 2097151, 0, 10, 0, 32767, 4'b1000);
        chk("relu cnt", 32'(actv_sat_cnt_o), 32'd1);
        run_beat("leaky", 2'b10, '0, -640, -64, 64, 32, -1, 0, 1, 1, 4'b0000);
        run_beat("clip", 2'b11, 15'd100, 12800, -5, 6400, 3200, 100, 0, 100, 50, 4'b0000);
        run_beat("bypass", 2'b00, '0, -2097152, -640, 2097151, 95, -32768, -10, 32767, 1, 4'b0100);
        chk("cnt after modes", 32'(actv_sat_cnt_o), 32'd2);

        // Backpressure: A and B fill the pipe, C waits
        actv_ready_i = 1'b0;
        drive(2'b01, '0, 64, -640, 0, 0);
        #1;
        chk("bp ready A", 32'(actv_ready_o), 32'd1);
        @(posedge actv_clk); #1;
        drive(2'b00, '0, 128, -640, 0, 0);
        #1;
        chk("bp ready B", 32'(actv_ready_o), 32'd1);
        @(posedge actv_clk); #1;
        drive(2'b01, '0, 192, 0, 0, 0);
        #1;
        chk("bp ready C blocked", 32'(actv_ready_o), 32'd0);
        chk("bp valid_o", 32'(actv_valid_o), 32'd1);
        chk_lane("bp hold A", 0, 1);
        @(posedge actv_clk); #1;
        @(posedge actv_clk); #1;
        chk("bp ready still 0", 32'(actv_ready_o), 32'd0);
        chk_lane("bp stable A", 0, 1);
        chk_lane("bp stable A", 1, 0);
        actv_ready_i = 1'b1;
        #1;
        chk("bp ready on release", 32'(actv_ready_o), 32'd1);
        @(posedge actv_clk); #1;
        actv_valid_i = 1'b0;
        chk("bp B valid", 32'(actv_valid_o), 32'd1);
        chk_lane("bp B", 0, 2);
        chk_lane("bp B", 1, -10);
        @(posedge actv_clk); #1;
        chk("bp C valid", 32'(actv_valid_o), 32'd1);
        chk_lane("bp C", 0, 3);
        @(posedge actv_clk); #1;
        chk("bp drained", 32'(actv_valid_o), 32'd0);

        // Counter clear, then saturate it past 0xFFFF
        actv_sat_clr_i = 1'b1;
        @(posedge actv_clk); #1;
        actv_sat_clr_i = 1'b0;
        chk("cnt clear", 32'(actv_sat_cnt_o), 32'd0);
        drive(2'b00, '0, 2097151, 0, 0, 0);
        for (int k = 0; k < 65537; k++) @(posedge actv_clk);
        #1;
        actv_valid_i = 1'b0;
        repeat (3) @(posedge actv_clk);
        #1;
        chk("cnt sticky", 32'(actv_sat_cnt_o), 32'hFFFF);
        chk("cnt stream drained", 32'(actv_valid_o), 32'd0);

        // Clear coincident with a saturating transfer wins
        drive(2'b00, '0, -2097152, 0, 0, 2097151);
        @(posedge actv_clk); #1;
        actv_valid_i = 1'b0;
        for (int k = 0; k < 5 && !actv_valid_o; k++) begin
            @(posedge actv_clk); #1;
        end
        chk("clr beat valid", 32'(actv_valid_o), 32'd1);
        chk("clr beat sat", 32'(actv_sat_o), 32'h8);
        actv_sat_clr_i = 1'b1;
        @(posedge actv_clk); #1;
        actv_sat_clr_i = 1'b0;
        chk("cnt clr wins", 32'(actv_sat_cnt_o), 32'd0);
        chk("clr beat gone", 32'(actv_valid_o), 32'd0);

        // Reset with two beats in flight
        run_beat("pre-rst", 2'b01, '0, 2097151, 0, 0, 0, 32767, 0, 0, 0, 4'b0001);
        chk("pre-rst cnt", 32'(actv_sat_cnt_o), 32'd1);
        actv_ready_i = 1'b0;
        drive(2'b00, '0, 2097151, 640, 0, 0);
        @(posedge actv_clk); #1;
        drive(2'b00, '0, 640, 640, 0, 0);
        @(posedge actv_clk); #1;
        actv_valid_i = 1'b0;
        chk("inflight valid_o", 32'(actv_valid_o), 32'd1);
        chk("inflight ready_o", 32'(actv_ready_o), 32'd0);
        #2;
        actv_rst_b = 1'b0;
        #1;
        chk("async rst valid_o", 32'(actv_valid_o), 32'd0);
        chk("async rst out", 32'(actv_out_o), 32'd0);
        chk("async rst sat", 32'(actv_sat_o), 32'd0);
        chk("async rst cnt", 32'(actv_sat_cnt_o), 32'd0);
        @(negedge actv_clk);
        actv_rst_b   = 1'b1;
        actv_ready_i = 1'b1;
        @(posedge actv_clk); #1;
        chk("rst release ready_o", 32'(actv_ready_o), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(posedge actv_clk); #1;
            chk($sformatf("no stale beat %0d", k), 32'(actv_valid_o), 32'd0);
        end
        chk("no stale count", 32'(actv_sat_cnt_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
